// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central sequencer for the 5-stage MIPS pipeline registers.
//               Produces per-stage load enables and bubble flushes for
//               load-use stalls, taken-branch flushes and multi-cycle
//               data-memory waits. Runs a data-memory req/ack handshake with
//               a timeout and keeps a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             dmem_req,
    output logic             timeout_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_LU_STALL = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [1:0] S_ERR      = 2'd3;

    // Wait counter must be able to hold MEM_TIMEOUT itself
    localparam int         WC_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] C_WAIT_LIMIT = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] C_WAIT_ONE   = WC_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_wait_cnt_nxt;
    logic             r_timeout_err;
    logic             w_err_set;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_mem_stall;

    logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic w_if_id_flush, w_id_ex_flush, w_dmem_req;

    assign w_load_use  = ex_mem_read && (ex_rd != '0) &&
                         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign w_mem_stall = mem_req && !mem_ack;

    // State, wait counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_err_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Next-state, wait-counter and error-set decode
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_set      = 1'b0;
        unique case (r_state)
            S_RUN, S_LU_STALL: begin
                if (w_mem_stall) begin
                    w_state_nxt    = S_MEM_WAIT;
                    w_wait_cnt_nxt = C_WAIT_ONE;
                end else if (ex_branch_taken) begin
                    w_state_nxt = S_RUN;
                end else if ((r_state == S_RUN) && w_load_use) begin
                    // The stall lasts one cycle; the hazard check is skipped in LU_STALL
                    w_state_nxt = S_LU_STALL;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == C_WAIT_LIMIT) begin
                    w_state_nxt = S_ERR;
                    w_err_set   = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + C_WAIT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    // Pipeline enables, flushes and memory request from state and inputs
    always_comb begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_dmem_req    = 1'b0;
        unique case (r_state)
            S_RUN, S_LU_STALL: begin
                w_dmem_req = mem_req;
                if (w_mem_stall) begin
                    {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '0;
                end else if (ex_branch_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if ((r_state == S_RUN) && w_load_use) begin
                    // Hold PC and IF/ID, inject a bubble into ID/EX
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // Request stays asserted until the ack cycle releases the pipeline
                w_dmem_req = 1'b1;
                if (!mem_ack) begin
                    {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '0;
                end
            end
            default: begin
                {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '0;
            end
        endcase
    end

    // Saturating count of stalled cycles outside the error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state != S_ERR) && !w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Controls are held low for as long as reset is asserted
    assign pc_en       = rst_n & w_pc_en;
    assign if_id_en    = rst_n & w_if_id_en;
    assign id_ex_en    = rst_n & w_id_ex_en;
    assign ex_mem_en   = rst_n & w_ex_mem_en;
    assign mem_wb_en   = rst_n & w_mem_wb_en;
    assign if_id_flush = rst_n & w_if_id_flush;
    assign id_ex_flush = rst_n & w_id_ex_flush;
    assign dmem_req    = rst_n & w_dmem_req;

    assign timeout_err = r_timeout_err;
    assign state       = r_state;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: directed
//               scenarios followed by randomized traffic against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int REG_W       = 5;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
    localparam int SAT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ack;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, dmem_req, timeout_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pipeline condition as plain flags and integers
    bit m_lu_pending;   // the cycle right after a load-use stall
    bit m_waiting;      // a data-memory access is outstanding
    bit m_failed;       // memory timeout has happened
    int m_wait_cycles;
    int m_stalls;

    // Expected outputs for the current cycle
    bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_ifid_fl, e_idex_fl, e_dmem;

    pipeline_hazard_ctrl #(
        .REG_W      (REG_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .dmem_req       (dmem_req),
        .timeout_err    (timeout_err),
        .state          (state),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hazard();
        // The instruction in ID needs a register the load in EX has not produced yet
        bit reads_rs, reads_rt;
        reads_rs = (id_rs == ex_rd);
        reads_rt = id_uses_rt && (id_rt == ex_rd);
        return ex_mem_read && (ex_rd != 0) && (reads_rs || reads_rt);
    endfunction

    function automatic logic [7:0] exp_vec();
        return {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_ifid_fl, e_idex_fl, e_dmem};
    endfunction

    function automatic int exp_state();
        if (m_failed)     return 3;
        if (m_waiting)    return 2;
        if (m_lu_pending) return 1;
        return 0;
    endfunction

    task automatic model_eval();
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
        {e_ifid_fl, e_idex_fl, e_dmem} = 3'b000;
        if (m_failed) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
        end else if (m_waiting) begin
            e_dmem = 1'b1;
            if (!mem_ack) {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
        end else begin
            e_dmem = mem_req;
            if (mem_req && !mem_ack) begin
                {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
            end else if (ex_branch_taken) begin
                e_ifid_fl = 1'b1;
                e_idex_fl = 1'b1;
            end else if (!m_lu_pending && hazard()) begin
                e_pc      = 1'b0;
                e_ifid    = 1'b0;
                e_idex_fl = 1'b1;
            end
        end
    endtask

    task automatic model_clock();
        if (!m_failed && !e_pc && m_stalls < SAT_MAX) m_stalls++;
        if (m_failed) begin
            // stays failed until reset
        end else if (m_waiting) begin
            if (mem_ack) begin
                m_waiting     = 1'b0;
                m_wait_cycles = 0;
            end else if (m_wait_cycles >= MEM_TIMEOUT) begin
                m_failed = 1'b1;
            end else begin
                m_wait_cycles++;
            end
        end else if (mem_req && !mem_ack) begin
            m_waiting     = 1'b1;
            m_wait_cycles = 1;
            m_lu_pending  = 1'b0;
        end else begin
            m_lu_pending = !ex_branch_taken && !m_lu_pending && hazard();
        end
    endtask

    task automatic model_reset();
        m_lu_pending  = 1'b0;
        m_waiting     = 1'b0;
        m_failed      = 1'b0;
        m_wait_cycles = 0;
        m_stalls      = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ctl"},   {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                if_id_flush, id_ex_flush, dmem_req}, {24'd0, exp_vec()});
        check({tag, ".state"}, {30'd0, state}, 32'(exp_state()));
        check({tag, ".terr"},  {31'd0, timeout_err}, {31'd0, m_failed});
        check({tag, ".scnt"},  {16'd0, stall_cnt}, 32'(m_stalls));
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic mrd, input logic [4:0] rd, input logic br,
                          input logic req, input logic ack);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd;
        ex_rd = rd; ex_branch_taken = br; mem_req = req; mem_ack = ack;
    endtask

    // One clock cycle: inputs already applied after the falling edge
    task automatic step(input string tag);
        model_eval();
        #1;
        check_all(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse applied mid-cycle
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_ctl"}, {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                  if_id_flush, id_ex_flush, dmem_req}, 32'd0);
        check({tag, ".rst_state"}, {30'd0, state}, 32'd0);
        check({tag, ".rst_scnt"},  {16'd0, stall_cnt}, 32'd0);
        check({tag, ".rst_terr"},  {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        pulse_reset("init");

        // Idle pipeline: everything flows
        step("idle");

        // Load-use on rs: one stall cycle, then back to RUN
        set_in(8, 3, 0, 1, 8, 0, 0, 0);
        step("lu1");
        step("lu2");
        set_in(1, 2, 0, 0, 0, 0, 0, 0);
        step("lu3");

        // Load-use via rt only when rt is actually read
        set_in(4, 9, 1, 1, 9, 0, 0, 0);
        step("lurt");
        set_in(4, 9, 0, 1, 9, 0, 0, 0);
        step("norte");

        // Load to $zero never stalls
        set_in(0, 0, 1, 1, 0, 0, 0, 0);
        step("zero");

        // Branch beats a simultaneous load-use
        set_in(8, 3, 0, 1, 8, 1, 0, 0);
        step("brlu");
        step("brlu2");

        // Single-cycle memory access
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        step("mem1");

        // Memory access acked after three frozen cycles
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step("mw0");
        step("mw1");
        step("mw2");
        mem_ack = 1'b1;
        step("mwack");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("mwpost");

        // Timeout with no ack
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) step("tmo");
        set_in(8, 8, 1, 1, 8, 1, 1, 1);
        step("err1");
        step("err2");
        pulse_reset("errrst");

        // Reset asserted during the second wait cycle
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step("rw0");
        step("rw1");
        pulse_reset("rwrst");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("rwpost");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req         = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
            mem_ack         = m_waiting ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
            step("rnd");
            if (m_failed && $urandom_range(0, 3) == 0) pulse_reset("rndrst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
